// File: rtl/nf_10g_stats_pkg.sv
// Shared constants for the 10G per-port statistics collector: counter
// indices within a port's register window, STATUS bit positions and the
// width of the per-frame length fields.
package nf_10g_stats_pkg;

    // Width of one per-port frame length field on rx_stat_len / tx_stat_len
    localparam int LEN_W = 15;

    // Counter index within a port's 8-entry register window
    localparam logic [2:0] IDX_RX_GOOD_PKTS  = 3'd0;
    localparam logic [2:0] IDX_RX_GOOD_BYTES = 3'd1;
    localparam logic [2:0] IDX_RX_BAD_PKTS   = 3'd2;
    localparam logic [2:0] IDX_TX_PKTS       = 3'd3;
    localparam logic [2:0] IDX_TX_BYTES      = 3'd4;
    localparam logic [2:0] IDX_LINK_DOWN     = 3'd5;
    localparam logic [2:0] IDX_STATUS        = 3'd6;
    localparam logic [2:0] IDX_RESERVED      = 3'd7;

    // STATUS word bit positions
    localparam int STATUS_LINK_UP_BIT = 0;
    localparam int STATUS_STICKY_BIT  = 1;

endpackage

// File: rtl/nf_10g_stats_counter.sv
// One statistics counter: optional clear-on-read, saturating or wrapping
// accumulate, and a global clear that overrides everything else.
// A clear-on-read coinciding with an increment restarts from zero and
// still takes the increment, so the event is not lost.
module nf_10g_stats_counter
    import nf_10g_stats_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SATURATE      = 1,
    parameter int CLEAR_ON_READ = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    input  logic [WIDTH-1:0] inc_val,
    input  logic             rd_clr,
    input  logic             clr_all,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] base_s;
    logic [WIDTH:0]   sum_s;

    // Next count: clear_all beats clear-on-read, which beats plain accumulate
    always_comb begin
        base_s = cnt_q;
        if ((CLEAR_ON_READ != 0) && rd_clr) begin
            base_s = '0;
        end else begin
            base_s = cnt_q;
        end
        sum_s = {1'b0, base_s} + {1'b0, inc_val};
        cnt_d = base_s;
        if (clr_all) begin
            cnt_d = '0;
        end else if (inc_en) begin
            if (sum_s[WIDTH] && (SATURATE != 0)) begin
                cnt_d = '1;
            end else begin
                cnt_d = sum_s[WIDTH-1:0];
            end
        end else begin
            cnt_d = base_s;
        end
    end

    // Counter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/nf_10g_port_stats.sv
// Per-port RX/TX frame and byte counters plus link-down tracking for up to
// eight 10G interfaces, read through a registered single-cycle port.
// Address is {port, index}; ports beyond C_NUM_PORTS read as zero and have
// no side effects.
module nf_10g_port_stats
    import nf_10g_stats_pkg::*;
#(
    parameter int C_NUM_PORTS      = 4,
    parameter int C_PKT_CNT_WIDTH  = 32,
    parameter int C_BYTE_CNT_WIDTH = 48,
    parameter int C_SATURATE       = 1,
    parameter int C_CLEAR_ON_READ  = 0,
    localparam int PORT_W          = $clog2(C_NUM_PORTS),
    localparam int ADDR_W          = 3 + PORT_W
) (
    input  logic                         axis_aclk,
    input  logic                         axis_aresetn,
    input  logic [C_NUM_PORTS-1:0]       rx_stat_valid,
    input  logic [C_NUM_PORTS-1:0]       rx_stat_good,
    input  logic [LEN_W*C_NUM_PORTS-1:0] rx_stat_len,
    input  logic [C_NUM_PORTS-1:0]       tx_stat_valid,
    input  logic [LEN_W*C_NUM_PORTS-1:0] tx_stat_len,
    input  logic [C_NUM_PORTS-1:0]       link_up,
    input  logic                         clear_all,
    input  logic                         rd_en,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [63:0]                  rd_data,
    output logic                         rd_valid
);

    localparam logic [C_PKT_CNT_WIDTH-1:0] PKT_ONE = {{(C_PKT_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [3:0]             rd_port_s;
    logic [2:0]             rd_idx_s;
    logic [C_NUM_PORTS-1:0] rd_hit_s;
    logic [C_NUM_PORTS-1:0] link_prev_q;
    logic [C_NUM_PORTS-1:0] link_down_s;
    logic [C_NUM_PORTS-1:0] sticky_q;
    logic [C_NUM_PORTS-1:0] sticky_d;
    logic [63:0]            rd_mux_s;
    logic [63:0]            rd_data_q;
    logic [63:0]            rd_data_d;
    logic                   rd_valid_q;

    logic [C_PKT_CNT_WIDTH-1:0]  rx_good_pkts_s  [C_NUM_PORTS];
    logic [C_BYTE_CNT_WIDTH-1:0] rx_good_bytes_s [C_NUM_PORTS];
    logic [C_PKT_CNT_WIDTH-1:0]  rx_bad_pkts_s   [C_NUM_PORTS];
    logic [C_PKT_CNT_WIDTH-1:0]  tx_pkts_s       [C_NUM_PORTS];
    logic [C_BYTE_CNT_WIDTH-1:0] tx_bytes_s      [C_NUM_PORTS];
    logic [C_PKT_CNT_WIDTH-1:0]  link_down_cnt_s [C_NUM_PORTS];

    assign rd_idx_s = rd_addr[2:0];

    // A single-port build has no port field in the address
    generate
        if (PORT_W > 0) begin : g_port_field
            assign rd_port_s = 4'(rd_addr[ADDR_W-1:3]);
        end else begin : g_no_port_field
            assign rd_port_s = 4'd0;
        end
    endgenerate

    // Falling edge of link_up against last cycle's value
    assign link_down_s = link_prev_q & ~link_up;

    // Per-port read hit; unimplemented ports never match
    always_comb begin
        rd_hit_s = '0;
        for (int p = 0; p < C_NUM_PORTS; p++) begin
            rd_hit_s[p] = rd_en && (rd_port_s == 4'(p));
        end
    end

    generate
        for (genvar p = 0; p < C_NUM_PORTS; p++) begin : g_port
            logic [LEN_W-1:0] rx_len_s;
            logic [LEN_W-1:0] tx_len_s;
            logic             rx_good_s;
            logic             rx_bad_s;

            assign rx_len_s  = rx_stat_len[LEN_W*p +: LEN_W];
            assign tx_len_s  = tx_stat_len[LEN_W*p +: LEN_W];
            assign rx_good_s = rx_stat_valid[p] & rx_stat_good[p];
            assign rx_bad_s  = rx_stat_valid[p] & ~rx_stat_good[p];

            nf_10g_stats_counter #(.WIDTH(C_PKT_CNT_WIDTH), .SATURATE(C_SATURATE), .CLEAR_ON_READ(C_CLEAR_ON_READ))
            u_rx_good_pkts (
                .clk(axis_aclk), .rst_n(axis_aresetn), .inc_en(rx_good_s), .inc_val(PKT_ONE),
                .rd_clr(rd_hit_s[p] && (rd_idx_s == IDX_RX_GOOD_PKTS)), .clr_all(clear_all),
                .cnt_o(rx_good_pkts_s[p])
            );

            nf_10g_stats_counter #(.WIDTH(C_BYTE_CNT_WIDTH), .SATURATE(C_SATURATE), .CLEAR_ON_READ(C_CLEAR_ON_READ))
            u_rx_good_bytes (
                .clk(axis_aclk), .rst_n(axis_aresetn), .inc_en(rx_good_s),
                .inc_val(C_BYTE_CNT_WIDTH'(rx_len_s)),
                .rd_clr(rd_hit_s[p] && (rd_idx_s == IDX_RX_GOOD_BYTES)), .clr_all(clear_all),
                .cnt_o(rx_good_bytes_s[p])
            );

            nf_10g_stats_counter #(.WIDTH(C_PKT_CNT_WIDTH), .SATURATE(C_SATURATE), .CLEAR_ON_READ(C_CLEAR_ON_READ))
            u_rx_bad_pkts (
                .clk(axis_aclk), .rst_n(axis_aresetn), .inc_en(rx_bad_s), .inc_val(PKT_ONE),
                .rd_clr(rd_hit_s[p] && (rd_idx_s == IDX_RX_BAD_PKTS)), .clr_all(clear_all),
                .cnt_o(rx_bad_pkts_s[p])
            );

            nf_10g_stats_counter #(.WIDTH(C_PKT_CNT_WIDTH), .SATURATE(C_SATURATE), .CLEAR_ON_READ(C_CLEAR_ON_READ))
            u_tx_pkts (
                .clk(axis_aclk), .rst_n(axis_aresetn), .inc_en(tx_stat_valid[p]), .inc_val(PKT_ONE),
                .rd_clr(rd_hit_s[p] && (rd_idx_s == IDX_TX_PKTS)), .clr_all(clear_all),
                .cnt_o(tx_pkts_s[p])
            );

            nf_10g_stats_counter #(.WIDTH(C_BYTE_CNT_WIDTH), .SATURATE(C_SATURATE), .CLEAR_ON_READ(C_CLEAR_ON_READ))
            u_tx_bytes (
                .clk(axis_aclk), .rst_n(axis_aresetn), .inc_en(tx_stat_valid[p]),
                .inc_val(C_BYTE_CNT_WIDTH'(tx_len_s)),
                .rd_clr(rd_hit_s[p] && (rd_idx_s == IDX_TX_BYTES)), .clr_all(clear_all),
                .cnt_o(tx_bytes_s[p])
            );

            nf_10g_stats_counter #(.WIDTH(C_PKT_CNT_WIDTH), .SATURATE(C_SATURATE), .CLEAR_ON_READ(C_CLEAR_ON_READ))
            u_link_down (
                .clk(axis_aclk), .rst_n(axis_aresetn), .inc_en(link_down_s[p]), .inc_val(PKT_ONE),
                .rd_clr(rd_hit_s[p] && (rd_idx_s == IDX_LINK_DOWN)), .clr_all(clear_all),
                .cnt_o(link_down_cnt_s[p])
            );
        end
    endgenerate

    // Sticky link-down: a new event wins over a same-cycle STATUS read so it is not lost
    always_comb begin
        sticky_d = sticky_q;
        for (int p = 0; p < C_NUM_PORTS; p++) begin
            if (clear_all) begin
                sticky_d[p] = 1'b0;
            end else if (link_down_s[p]) begin
                sticky_d[p] = 1'b1;
            end else if (rd_hit_s[p] && (rd_idx_s == IDX_STATUS)) begin
                sticky_d[p] = 1'b0;
            end else begin
                sticky_d[p] = sticky_q[p];
            end
        end
    end

    // Previous link state and sticky flags
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            link_prev_q <= '0;
            sticky_q    <= '0;
        end else begin
            link_prev_q <= link_up;
            sticky_q    <= sticky_d;
        end
    end

    // Read mux over current counter values; unmatched port or reserved index gives 0
    always_comb begin
        rd_mux_s = 64'd0;
        for (int p = 0; p < C_NUM_PORTS; p++) begin
            if (rd_port_s == 4'(p)) begin
                case (rd_idx_s)
                    IDX_RX_GOOD_PKTS:  rd_mux_s = 64'(rx_good_pkts_s[p]);
                    IDX_RX_GOOD_BYTES: rd_mux_s = 64'(rx_good_bytes_s[p]);
                    IDX_RX_BAD_PKTS:   rd_mux_s = 64'(rx_bad_pkts_s[p]);
                    IDX_TX_PKTS:       rd_mux_s = 64'(tx_pkts_s[p]);
                    IDX_TX_BYTES:      rd_mux_s = 64'(tx_bytes_s[p]);
                    IDX_LINK_DOWN:     rd_mux_s = 64'(link_down_cnt_s[p]);
                    IDX_STATUS: begin
                        rd_mux_s                     = 64'd0;
                        rd_mux_s[STATUS_LINK_UP_BIT] = link_up[p];
                        rd_mux_s[STATUS_STICKY_BIT]  = sticky_q[p];
                    end
                    default:           rd_mux_s = 64'd0;
                endcase
            end else begin
                rd_mux_s = rd_mux_s;
            end
        end
    end

    // Read data is captured only on a strobe and held between reads
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_mux_s;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Registered read response
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            rd_data_q  <= 64'd0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_nf_10g_port_stats.sv
// Directed bench for nf_10g_port_stats. Two instances share the statistic
// inputs: A saturates and keeps counters on read, B wraps and clears on
// read. Each has its own read port. Both are 3-port builds with 8-bit
// packet and 16-bit byte counters, so port 3 is an unimplemented address.
module tb_nf_10g_port_stats;

    localparam int NP = 3;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          axis_aresetn;
    logic [NP-1:0] rx_stat_valid, rx_stat_good, tx_stat_valid, link_up;
    logic [44:0]   rx_stat_len, tx_stat_len;
    logic          clear_all;
    logic          rd_en_a, rd_en_b;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic [63:0]   rd_data_a, rd_data_b;
    logic          rd_valid_a, rd_valid_b;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          phase;
        bit          dut_b;
        logic [4:0]  addr;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    nf_10g_port_stats #(
        .C_NUM_PORTS(NP), .C_PKT_CNT_WIDTH(8), .C_BYTE_CNT_WIDTH(16),
        .C_SATURATE(1), .C_CLEAR_ON_READ(0)
    ) u_dut_a (
        .axis_aclk(clk), .axis_aresetn(axis_aresetn),
        .rx_stat_valid(rx_stat_valid), .rx_stat_good(rx_stat_good), .rx_stat_len(rx_stat_len),
        .tx_stat_valid(tx_stat_valid), .tx_stat_len(tx_stat_len), .link_up(link_up),
        .clear_all(clear_all), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    nf_10g_port_stats #(
        .C_NUM_PORTS(NP), .C_PKT_CNT_WIDTH(8), .C_BYTE_CNT_WIDTH(16),
        .C_SATURATE(0), .C_CLEAR_ON_READ(1)
    ) u_dut_b (
        .axis_aclk(clk), .axis_aresetn(axis_aresetn),
        .rx_stat_valid(rx_stat_valid), .rx_stat_good(rx_stat_good), .rx_stat_len(rx_stat_len),
        .tx_stat_valid(tx_stat_valid), .tx_stat_len(tx_stat_len), .link_up(link_up),
        .clear_all(clear_all), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    function automatic void add(input int ph, input bit b, input int port, input int idx,
                                input longint unsigned exp);
        vec_t v;
        v.phase = ph;
        v.dut_b = b;
        v.addr  = 5'(port * 8 + idx);
        v.exp   = 64'(exp);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one read at a negedge; result is checked at the next negedge
    task automatic do_read(input bit b, input logic [4:0] addr, input logic [63:0] exp);
        string nm;
        nm = $sformatf("%s_p%0d_i%0d", b ? "B" : "A", addr[4:3], addr[2:0]);
        if (b) begin
            rd_en_b = 1'b1; rd_addr_b = addr;
        end else begin
            rd_en_a = 1'b1; rd_addr_a = addr;
        end
        @(negedge clk);
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
        chk({nm, "_valid"}, 64'(b ? rd_valid_b : rd_valid_a), 64'd1);
        chk({nm, "_data"}, b ? rd_data_b : rd_data_a, exp);
    endtask

    task automatic run_phase(input int ph);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].phase == ph) begin
                do_read(vecs[i].dut_b, vecs[i].addr, vecs[i].exp);
            end
        end
    endtask

    task automatic rx_frame(input int p, input bit good, input int len);
        rx_stat_valid = '0;
        rx_stat_valid[p] = 1'b1;
        rx_stat_good[p] = good;
        rx_stat_len[15*p +: 15] = 15'(len);
        @(negedge clk);
        rx_stat_valid = '0;
    endtask

    initial begin
        // Phase 1: everything zero after reset (link down, nothing counted)
        for (int i = 0; i < 8; i++) add(1, 1'b0, 0, i, 0);
        for (int i = 0; i < 8; i++) add(1, 1'b0, 2, i, 0);
        add(1, 1'b0, 3, 0, 0);
        add(1, 1'b1, 0, 3, 0);
        add(1, 1'b1, 2, 6, 0);
        // Phase 2: after RX on port 1, 257 TX of 300 bytes on port 0, two link drops on port 2
        add(2, 1'b0, 1, 0, 3);     add(2, 1'b0, 1, 1, 10582); add(2, 1'b0, 1, 2, 1);
        add(2, 1'b0, 1, 3, 0);     add(2, 1'b0, 1, 4, 0);     add(2, 1'b0, 1, 5, 0);
        add(2, 1'b0, 1, 6, 1);     add(2, 1'b0, 1, 7, 0);
        add(2, 1'b0, 0, 3, 255);   add(2, 1'b0, 0, 4, 65535); add(2, 1'b0, 0, 0, 0);
        add(2, 1'b0, 0, 6, 1);
        add(2, 1'b0, 2, 5, 2);     add(2, 1'b0, 2, 6, 2);     add(2, 1'b0, 2, 6, 0);
        add(2, 1'b0, 2, 0, 0);
        add(2, 1'b0, 3, 1, 0);     add(2, 1'b0, 3, 6, 0);
        add(2, 1'b1, 0, 3, 1);     add(2, 1'b1, 0, 4, 11564); add(2, 1'b1, 0, 4, 0);
        add(2, 1'b1, 0, 3, 0);
        add(2, 1'b1, 1, 0, 3);     add(2, 1'b1, 1, 1, 10582); add(2, 1'b1, 1, 1, 0);
        add(2, 1'b1, 1, 2, 1);
        add(2, 1'b1, 2, 5, 2);     add(2, 1'b1, 2, 5, 0);     add(2, 1'b1, 2, 6, 2);
        add(2, 1'b1, 2, 6, 0);
        // Phase 4: immediately after clear_all with a coincident frame on every port
        add(4, 1'b0, 0, 0, 0);     add(4, 1'b0, 0, 1, 0);     add(4, 1'b0, 0, 3, 0);
        add(4, 1'b0, 0, 4, 0);     add(4, 1'b0, 0, 5, 0);     add(4, 1'b0, 0, 6, 0);
        add(4, 1'b0, 1, 0, 0);     add(4, 1'b0, 1, 1, 0);     add(4, 1'b0, 1, 2, 0);
        add(4, 1'b0, 2, 0, 0);     add(4, 1'b0, 2, 1, 0);
        add(4, 1'b1, 0, 4, 0);     add(4, 1'b1, 1, 0, 0);     add(4, 1'b1, 2, 1, 0);
        // Phase 5: one more frame each way counts from zero
        add(5, 1'b0, 0, 0, 1);     add(5, 1'b0, 0, 1, 50);    add(5, 1'b0, 2, 3, 1);
        add(5, 1'b0, 2, 4, 7);     add(5, 1'b1, 0, 0, 1);     add(5, 1'b1, 0, 1, 50);
        add(5, 1'b1, 2, 3, 1);

        // Reset with statistic pulses active; they must be ignored
        axis_aresetn  = 1'b0;
        rx_stat_valid = '1;  rx_stat_good = '1;  rx_stat_len = '1;
        tx_stat_valid = '1;  tx_stat_len  = '1;  link_up = '0;
        clear_all = 1'b0;
        rd_en_a = 1'b0;  rd_en_b = 1'b0;  rd_addr_a = '0;  rd_addr_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid_a", 64'(rd_valid_a), 64'd0);
        chk("rst_data_a", rd_data_a, 64'd0);
        chk("rst_valid_b", 64'(rd_valid_b), 64'd0);
        chk("rst_data_b", rd_data_b, 64'd0);
        axis_aresetn  = 1'b1;
        rx_stat_valid = '0;  tx_stat_valid = '0;
        rx_stat_len   = '0;  tx_stat_len   = '0;
        @(negedge clk);
        run_phase(1);

        // Phase 2 stimulus
        link_up = 3'b111;
        @(negedge clk);
        rx_frame(1, 1'b1, 64);
        rx_frame(1, 1'b1, 1518);
        rx_frame(1, 1'b1, 9000);
        rx_frame(1, 1'b0, 100);
        tx_stat_valid[0] = 1'b1;
        tx_stat_len[14:0] = 15'd300;
        repeat (257) @(negedge clk);
        tx_stat_valid = '0;
        link_up[2] = 1'b0; repeat (2) @(negedge clk);
        link_up[2] = 1'b1; repeat (2) @(negedge clk);
        link_up[2] = 1'b0; repeat (2) @(negedge clk);
        run_phase(2);

        // rd_data holds and rd_valid drops after a single read
        do_read(1'b0, 5'd9, 64'd10582);
        @(negedge clk);
        chk("hold_valid_a", 64'(rd_valid_a), 64'd0);
        chk("hold_data_a", rd_data_a, 64'd10582);

        // Read coincident with increment on A returns the pre-increment value
        rd_en_a = 1'b1;  rd_addr_a = 5'd8;
        rx_stat_valid[1] = 1'b1;  rx_stat_good[1] = 1'b1;  rx_stat_len[29:15] = 15'd10;
        @(negedge clk);
        rd_en_a = 1'b0;  rx_stat_valid = '0;
        chk("A_rd_inc_same_cycle", rd_data_a, 64'd3);
        do_read(1'b0, 5'd8, 64'd4);
        do_read(1'b0, 5'd9, 64'd10592);

        // Clear-on-read coincident with a 64-byte TX on B: event must survive
        tx_stat_valid[0] = 1'b1;  tx_stat_len[14:0] = 15'd100;
        @(negedge clk);
        tx_stat_valid[0] = 1'b1;  tx_stat_len[14:0] = 15'd64;
        rd_en_b = 1'b1;  rd_addr_b = 5'd4;
        @(negedge clk);
        rd_en_b = 1'b0;  tx_stat_valid = '0;
        chk("B_cor_inc_prior", rd_data_b, 64'd100);
        do_read(1'b1, 5'd4, 64'd64);
        do_read(1'b1, 5'd4, 64'd0);
        do_read(1'b1, 5'd3, 64'd2);
        do_read(1'b0, 5'd4, 64'd65535);
        do_read(1'b0, 5'd3, 64'd255);

        // Link drop on port 0, then clear_all together with a frame on every port
        link_up[0] = 1'b0;
        @(negedge clk);
        do_read(1'b0, 5'd5, 64'd1);
        clear_all = 1'b1;
        rx_stat_valid = 3'b111;  rx_stat_good = 3'b111;
        rx_stat_len = {15'd50, 15'd50, 15'd50};
        @(negedge clk);
        clear_all = 1'b0;  rx_stat_valid = '0;
        run_phase(4);

        // First events after the clear
        rx_stat_valid = 3'b001;  rx_stat_good = 3'b001;  rx_stat_len[14:0] = 15'd50;
        tx_stat_valid = 3'b100;  tx_stat_len[44:30] = 15'd7;
        @(negedge clk);
        rx_stat_valid = '0;  tx_stat_valid = '0;
        run_phase(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
